// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: board-logic side and pin side signals of the scanned 7-segment driver
interface seg_scan_display_if #(
  parameter int DIGITS = 8,
  parameter int SEL_W = 3
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0] dp_in;
  logic [DIGITS-1:0] blank_mask;
  logic [DIGITS-1:0] blink_mask;
  logic lz_en;
  logic load;
  logic [SEL_W-1:0] which;
  logic [7:0] seg;
  logic frame_tick;
  logic pending;
  modport master(
    output data, dp_in, blank_mask, blink_mask, lz_en, load,
    input which, seg, frame_tick, pending
  );
  modport slave(
    input data, dp_in, blank_mask, blink_mask, lz_en, load,
    output which, seg, frame_tick, pending
  );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: N-digit multiplexed 7-segment driver with frame-synchronous update, blank/blink/dp and leading-zero suppression
module seg_scan_display #(
  parameter int DIGITS = 8,
  parameter int SEL_W = 3,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int SEG_ACT_LOW = 0
) (
  input logic clk,
  input logic rst,
  seg_scan_display_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] DARK = SEG_ACT_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [PW-1:0] pre;
  logic [SEL_W-1:0] idx;
  logic [4*DIGITS-1:0] act_d, sh_d;
  logic [DIGITS-1:0] act_dp, sh_dp, zero_up;
  logic [BW-1:0] bcnt;
  logic blink_off, adv, wrap, dark, z;
  logic [3:0] nib;
  logic [7:0] lit;
  always_comb begin
    adv = pre == PW'(SCAN_DIV - 1);
    wrap = adv && idx == SEL_W'(DIGITS - 1);
    z = 1'b1;
    zero_up = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z & (act_d[4*k +: 4] == 4'd0);
      zero_up[k] = z;
    end
    nib = act_d[4*idx +: 4];
    lit = {act_dp[idx], HEX[nib]};
    dark = bus.blank_mask[idx] | (bus.blink_mask[idx] & blink_off) |
           (bus.lz_en & (idx != '0) & zero_up[idx]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      act_d <= '0;
      act_dp <= '0;
      sh_d <= '0;
      sh_dp <= '0;
      bcnt <= '0;
      blink_off <= 1'b0;
      bus.which <= '0;
      bus.seg <= DARK;
      bus.frame_tick <= 1'b0;
      bus.pending <= 1'b0;
    end else begin
      pre <= adv ? '0 : pre + 1'b1;
      if (adv) idx <= wrap ? '0 : idx + 1'b1;
      bus.which <= idx;
      bus.seg <= dark ? DARK : lit ^ DARK;
      bus.frame_tick <= wrap;
      if (wrap && bus.load) begin
        act_d <= bus.data;
        act_dp <= bus.dp_in;
        bus.pending <= 1'b0;
      end else if (wrap && bus.pending) begin
        act_d <= sh_d;
        act_dp <= sh_dp;
        bus.pending <= 1'b0;
      end else if (bus.load) begin
        sh_d <= bus.data;
        sh_dp <= bus.dp_in;
        bus.pending <= 1'b1;
      end
      if (wrap) begin
        bcnt <= bcnt == BW'(BLINK_FRAMES - 1) ? '0 : bcnt + 1'b1;
        if (bcnt == BW'(BLINK_FRAMES - 1)) blink_off <= ~blink_off;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed checks of scan timing, framed update, lz suppression, blink and reset
module tb_seg_scan_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_tick;
  int n;
  seg_scan_display_if #(.DIGITS(8), .SEL_W(3)) bus();
  seg_scan_display #(
    .DIGITS(8), .SEL_W(3), .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACT_LOW(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic wait_which(input logic [2:0] k, input string tag);
    for (int i = 0; i < 200 && bus.which !== k; i++) tick();
    check({tag, "_which"}, 32'(bus.which), 32'(k));
  endtask
  task automatic wait_tick(input string tag);
    for (int i = 0; i < 100 && bus.frame_tick !== 1'b1; i++) tick();
    check({tag, "_ftick"}, 32'(bus.frame_tick), 32'd1);
  endtask
  task automatic load_data(input logic [31:0] d, input logic [7:0] dp);
    bus.data = d;
    bus.dp_in = dp;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask
  initial begin
    logic [7:0] lz_exp [8];
    lz_exp = '{8'h3F, 8'h6D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.data = '0;
    bus.dp_in = '0;
    bus.blank_mask = '0;
    bus.blink_mask = '0;
    bus.lz_en = 1'b0;
    bus.load = 1'b0;
    tick();
    tick();
    check("rst_seg", 32'(bus.seg), 32'h00);
    check("rst_which", 32'(bus.which), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_ftick", 32'(bus.frame_tick), 32'd0);
    rst = 1'b0;
    load_data(32'h0123_4567, 8'h00);
    check("t1_pending", 32'(bus.pending), 32'd1);
    check("t1_old_d0", 32'(bus.seg), 32'h3F);
    wait_tick("t1");
    check("t1_commit", 32'(bus.pending), 32'd0);
    tick();
    check("t1_d0_which", 32'(bus.which), 32'd0);
    check("t1_d0", 32'(bus.seg), 32'h07);
    wait_which(3'd1, "t1_d1");
    n = 0;
    while (bus.which !== 3'd2 && n < 50) begin
      tick();
      n++;
    end
    check("t1_slot_len", 32'(n), 32'd4);
    wait_which(3'd3, "t1_d3");
    check("t1_d3", 32'(bus.seg), 32'h66);
    wait_which(3'd7, "t1_d7");
    check("t1_d7", 32'(bus.seg), 32'h3F);
    wait_which(3'd3, "t2_d3");
    load_data(32'h89AB_CDEF, 8'h00);
    check("t2_pending", 32'(bus.pending), 32'd1);
    wait_which(3'd4, "t2_d4");
    check("t2_old_d4", 32'(bus.seg), 32'h4F);
    wait_which(3'd7, "t2_d7");
    check("t2_old_d7", 32'(bus.seg), 32'h3F);
    check("t2_still_pend", 32'(bus.pending), 32'd1);
    wait_tick("t2");
    check("t2_commit", 32'(bus.pending), 32'd0);
    tick();
    check("t2_new_d0", 32'(bus.seg), 32'h71);
    wait_which(3'd7, "t2_d7n");
    check("t2_new_d7", 32'(bus.seg), 32'h7F);
    bus.lz_en = 1'b1;
    load_data(32'h0000_0050, 8'h00);
    wait_tick("t3");
    tick();
    for (int k = 0; k < 8; k++) begin
      wait_which(3'(k), $sformatf("t3_d%0d", k));
      check($sformatf("t3_seg%0d", k), 32'(bus.seg), 32'(lz_exp[k]));
    end
    bus.lz_en = 1'b0;
    wait_which(3'd4, "t6_d4");
    load_data(32'hFFFF_FFFF, 8'hFF);
    check("t6_pending", 32'(bus.pending), 32'd1);
    wait_which(3'd5, "t6_d5");
    rst = 1'b1;
    tick();
    check("t6_seg", 32'(bus.seg), 32'h00);
    check("t6_which", 32'(bus.which), 32'd0);
    check("t6_pending", 32'(bus.pending), 32'd0);
    rst = 1'b0;
    bus.blink_mask = 8'h01;
    bus.data = '0;
    bus.dp_in = '0;
    tick();
    check("t4_f0_which", 32'(bus.which), 32'd0);
    check("t4_f0", 32'(bus.seg), 32'h3F);
    last_tick = 0;
    for (int f = 1; f <= 5; f++) begin
      wait_tick($sformatf("t4_f%0d", f));
      if (f >= 2) check($sformatf("t4_period%0d", f), 32'(cyc - last_tick), 32'd32);
      last_tick = cyc;
      tick();
      check($sformatf("t4_d0_f%0d", f), 32'(bus.seg), ((f / 2) % 2) ? 32'h00 : 32'h3F);
      if (f == 2) begin
        wait_which(3'd1, "t4_d1");
        check("t4_d1_lit", 32'(bus.seg), 32'h3F);
      end
    end
    bus.blink_mask = 8'h00;
    wait_which(3'd7, "t5_d7");
    tick();
    tick();
    load_data(32'h0123_4567, 8'h80);
    check("t5_pending", 32'(bus.pending), 32'd0);
    check("t5_ftick", 32'(bus.frame_tick), 32'd1);
    tick();
    check("t5_d0", 32'(bus.seg), 32'h07);
    wait_which(3'd7, "t5_d7n");
    check("t5_d7_dp", 32'(bus.seg), 32'hBF);
    check("t5_pending2", 32'(bus.pending), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
